// File: rtl/fft_stream_io_pkg.sv
// Shared definitions for the FFT streaming front/back end.
// Holds the point count, the bank/address split of a 2048-point index,
// the control state encoding, and a bank-to-write-enable decoder.
package fft_stream_io_pkg;

  localparam int N_POINTS = 2048;

  // Point index k = {bank, addr}
  localparam int BANK_HI = 10;
  localparam int BANK_LO = 9;
  localparam int ADDR_HI = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    return 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry valid/ready buffer for {data, index, last}.
// Absorbs the one-cycle RAM read latency: the producer issues a read only
// when an entry will be free, so a returning read is never refused.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_data/s_index/s_last   write side (no ready; caller holds credit)
//   m_valid/m_data/m_index/m_last   read side, held stable until m_ready
//   m_ready                  downstream accept
//   count                    occupied entries (0..2)
module fft_skid_buf #(
  parameter int DATA_W = 17,
  parameter int IDX_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [IDX_W-1:0]  s_index,
  input  logic              s_last,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_index,
  output logic              m_last,
  input  logic              m_ready,
  output logic [1:0]        count
);

  localparam int W = DATA_W + IDX_W + 1;

  logic [W-1:0] ent0, ent1, head;
  logic         wptr, rptr;
  logic [1:0]   cnt;
  logic         push, pop;

  assign m_valid = (cnt != 2'd0);
  assign pop     = m_valid && m_ready;
  assign push    = s_valid && ((cnt != 2'd2) || pop);
  assign head    = rptr ? ent1 : ent0;
  assign {m_data, m_index, m_last} = head;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) begin
        if (wptr) ent1 <= {s_data, s_index, s_last};
        else      ent0 <= {s_data, s_index, s_last};
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fft_stream_io.sv
// Streaming front/back end for the 2048-point radix-4 FFT core.
// Loads 2048 real samples into the core's four input banks, pulses start,
// waits for a rising edge of the core ready flag, then streams the four
// banks' real results out in bank-major natural order.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_LOAD   | accepting samples, writing bank n[10:9] addr n[8:0]
// ST_START  | last write on the bus; start pulse follows next cycle
// ST_WAIT   | core running; waiting for iRDY low->high
// ST_UNLOAD | reading banks through the skid buffer to oM_*
//
// Ports:
//   iCLK, iRESET              clock, synchronous active-high reset
//   iS_DATA/iS_VALID/oS_READY input sample stream
//   oDATA/oADDR_WR/oWE_0..3   registered core write port (shared data/addr)
//   oSTART                    one-cycle core start pulse
//   iRDY                      core ready level
//   oADDR_RD, iDATA_RE_0..3   core read port, data one cycle after address
//   oM_DATA/oM_INDEX/oM_LAST/oM_VALID/iM_READY  result stream
//   oBUSY                     low only when idle in LOAD with no samples
module fft_stream_io
  import fft_stream_io_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [DATA_W-1:0] iS_DATA,
  input  logic              iS_VALID,
  output logic              oS_READY,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W-1:0] oADDR_WR,
  output logic              oWE_0,
  output logic              oWE_1,
  output logic              oWE_2,
  output logic              oWE_3,
  output logic              oSTART,
  input  logic              iRDY,
  output logic [ADDR_W-1:0] oADDR_RD,
  input  logic [DATA_W:0]   iDATA_RE_0,
  input  logic [DATA_W:0]   iDATA_RE_1,
  input  logic [DATA_W:0]   iDATA_RE_2,
  input  logic [DATA_W:0]   iDATA_RE_3,
  output logic [DATA_W:0]   oM_DATA,
  output logic [ADDR_W+1:0] oM_INDEX,
  output logic              oM_LAST,
  output logic              oM_VALID,
  input  logic              iM_READY,
  output logic              oBUSY
);

  localparam int IDX_W = ADDR_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  state_t state, state_nx;

  logic [IDX_W-1:0]  wr_cnt, rd_cnt, pend_idx;
  logic              rd_all, rdy_q, start_q, pend_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_wr_q;
  logic [3:0]        we_q;
  logic              s_accept, rd_issue, rdy_rise;
  logic [DATA_W:0]   rd_data;
  logic [1:0]        buf_cnt;
  logic              buf_valid, buf_last, buf_pop;

  assign oS_READY = (state == ST_LOAD) && !iRESET;
  assign s_accept = iS_VALID && oS_READY;
  assign rdy_rise = iRDY && !rdy_q;
  assign buf_pop  = buf_valid && iM_READY;

  // Issue a read only if the buffer can take it once it returns: entries
  // held plus the read already in flight, less the beat leaving now.
  assign rd_issue = (state == ST_UNLOAD) && !rd_all &&
                    (({1'b0, buf_cnt} + {2'b00, pend_q} - {2'b00, buf_pop}) < 3'd2);

  always_ff @(posedge iCLK) begin
    if (iRESET) state <= ST_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:   if (s_accept && (wr_cnt == LAST_IDX)) state_nx = ST_START;
      ST_START:  state_nx = ST_WAIT;
      ST_WAIT:   if (rdy_rise) state_nx = ST_UNLOAD;
      ST_UNLOAD: if (buf_pop && buf_last) state_nx = ST_LOAD;
      default:   state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      pend_idx  <= '0;
      rd_all    <= 1'b0;
      rdy_q     <= 1'b0;
      start_q   <= 1'b0;
      pend_q    <= 1'b0;
      data_q    <= '0;
      addr_wr_q <= '0;
      we_q      <= 4'b0000;
    end else begin
      rdy_q   <= iRDY;
      start_q <= (state == ST_START);
      we_q    <= 4'b0000;
      if (s_accept) begin
        data_q    <= iS_DATA;
        addr_wr_q <= wr_cnt[ADDR_HI:0];
        we_q      <= bank_onehot(wr_cnt[BANK_HI:BANK_LO]);
        wr_cnt    <= wr_cnt + 1'b1;
      end
      pend_q <= rd_issue;
      if (rd_issue) begin
        pend_idx <= rd_cnt;
        rd_cnt   <= rd_cnt + 1'b1;
        if (rd_cnt == LAST_IDX) rd_all <= 1'b1;
      end
      if ((state == ST_UNLOAD) && (state_nx == ST_LOAD)) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
        rd_all <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = iDATA_RE_0;
    case (pend_idx[BANK_HI:BANK_LO])
      2'd1:    rd_data = iDATA_RE_1;
      2'd2:    rd_data = iDATA_RE_2;
      2'd3:    rd_data = iDATA_RE_3;
      default: rd_data = iDATA_RE_0;
    endcase
  end

  fft_skid_buf #(
    .DATA_W (DATA_W + 1),
    .IDX_W  (IDX_W)
  ) u_skid (
    .clk     (iCLK),
    .rst     (iRESET),
    .s_valid (pend_q),
    .s_data  (rd_data),
    .s_index (pend_idx),
    .s_last  (pend_idx == LAST_IDX),
    .m_valid (buf_valid),
    .m_data  (oM_DATA),
    .m_index (oM_INDEX),
    .m_last  (buf_last),
    .m_ready (iM_READY),
    .count   (buf_cnt)
  );

  assign oDATA    = data_q;
  assign oADDR_WR = addr_wr_q;
  assign {oWE_3, oWE_2, oWE_1, oWE_0} = we_q;
  assign oSTART   = start_q;
  assign oADDR_RD = rd_cnt[ADDR_HI:0];
  assign oM_VALID = buf_valid;
  // Buffer entries keep stale contents after a pop; gate so LAST only
  // marks a live beat.
  assign oM_LAST  = buf_valid && buf_last;
  assign oBUSY    = !((state == ST_LOAD) && (wr_cnt == '0));

endmodule

// File: tb/tb_fft_stream_io.sv
// Directed bench for fft_stream_io: write scoreboard on the load side,
// result scoreboard on the unload side, behavioural bank RAM returning
// k + 1000 for point k.
module tb_fft_stream_io;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        iRESET, iS_VALID, iRDY, iM_READY;
  logic [15:0] iS_DATA;
  logic        oS_READY, oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oM_LAST, oM_VALID, oBUSY;
  logic [15:0] oDATA;
  logic [8:0]  oADDR_WR, oADDR_RD;
  logic [16:0] oM_DATA;
  logic [10:0] oM_INDEX;
  logic [16:0] ram_q [4];
  logic [3:0]  we_v;

  assign we_v = {oWE_3, oWE_2, oWE_1, oWE_0};

  fft_stream_io dut (
    .iCLK(clk), .iRESET(iRESET),
    .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
    .oDATA(oDATA), .oADDR_WR(oADDR_WR),
    .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
    .oSTART(oSTART), .iRDY(iRDY), .oADDR_RD(oADDR_RD),
    .iDATA_RE_0(ram_q[0]), .iDATA_RE_1(ram_q[1]),
    .iDATA_RE_2(ram_q[2]), .iDATA_RE_3(ram_q[3]),
    .oM_DATA(oM_DATA), .oM_INDEX(oM_INDEX), .oM_LAST(oM_LAST),
    .oM_VALID(oM_VALID), .iM_READY(iM_READY), .oBUSY(oBUSY)
  );

  // Core output RAM: one-cycle read latency, bank b address a holds b*512+a+1000
  always @(posedge clk)
    for (int b = 0; b < 4; b++) ram_q[b] <= 17'(b * 512 + int'(oADDR_RD) + 1000);

  typedef struct {
    logic [3:0]  we;
    logic [8:0]  addr;
    logic [15:0] data;
    int          n;
  } wr_t;

  wr_t wr_q[$];
  int  out_q[$];
  int  n_checks = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_write;
    wr_t e;
    if (wr_q.size() > 0) begin
      e = wr_q.pop_front();
      check("wr_we", 32'(we_v), 32'(e.we));
      check("wr_addr", 32'(oADDR_WR), 32'(e.addr));
      check("wr_data", 32'(oDATA), 32'(e.data));
      if (e.n == 600) begin
        check("ramp_600_bank1", 32'(we_v), 32'd2);
        check("ramp_600_addr88", 32'(oADDR_WR), 32'd88);
      end
    end else begin
      check("idle_we", 32'(we_v), 32'd0);
    end
  endtask

  task automatic check_reset_vals;
    check("rst_s_ready", 32'(oS_READY), 0);
    check("rst_we", 32'(we_v), 0);
    check("rst_start", 32'(oSTART), 0);
    check("rst_m_valid", 32'(oM_VALID), 0);
    check("rst_m_last", 32'(oM_LAST), 0);
    check("rst_data", 32'(oDATA), 0);
    check("rst_addr_wr", 32'(oADDR_WR), 0);
    check("rst_addr_rd", 32'(oADDR_RD), 0);
    check("rst_m_data", 32'(oM_DATA), 0);
    check("rst_m_index", 32'(oM_INDEX), 0);
    check("rst_busy", 32'(oBUSY), 0);
  endtask

  task automatic do_reset;
    iRESET = 1'b1;
    iS_VALID = 1'b0;
    tick;
    check_reset_vals();
    tick;
    check_reset_vals();
    iRESET = 1'b0;
    wr_q.delete();
    out_q.delete();
    #1;
    check("post_rst_s_ready", 32'(oS_READY), 1);
    check("post_rst_busy", 32'(oBUSY), 0);
  endtask

  task automatic do_load(input int count, input bit rand_valid, input bit ramp);
    int n = 0;
    int guard = 0;
    while (n < count && guard < 20000) begin
      bit  v;
      wr_t e;
      v = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      iS_VALID = v;
      iS_DATA  = ramp ? 16'(n) : 16'($urandom);
      if (v) begin
        check("s_ready_load", 32'(oS_READY), 1);
        e.we = 4'(1 << (n / 512));
        e.addr = 9'(n % 512);
        e.data = iS_DATA;
        e.n = n;
        wr_q.push_back(e);
        n++;
      end
      check("no_start_in_load", 32'(oSTART), 0);
      tick;
      check_write();
      guard++;
    end
    iS_VALID = 1'b0;
    if (n < count) check("load_timeout", 32'(n), 32'(count));
  endtask

  // Called right after the last write is on the bus; iRDY is already high.
  task automatic do_start_wait(input int hold);
    iS_VALID = 1'b1;
    iS_DATA  = 16'hBEEF;
    check("s_ready_start", 32'(oS_READY), 0);
    tick;
    check("start_pulse", 32'(oSTART), 1);
    check("s_ready_wait", 32'(oS_READY), 0);
    check_write();
    for (int i = 0; i < hold; i++) begin
      tick;
      check("start_once", 32'(oSTART), 0);
      check_write();
      check("no_unload_rdy_level", 32'(oM_VALID), 0);
      check("s_ready_wait", 32'(oS_READY), 0);
      check("busy_wait", 32'(oBUSY), 1);
    end
    iS_VALID = 1'b0;
  endtask

  task automatic do_trigger;
    iM_READY = 1'b0;
    iRDY = 1'b0;
    tick;
    iRDY = 1'b1;
    tick;
    check("unload_lat_c0", 32'(oM_VALID), 0);
    tick;
    check("unload_lat_c1", 32'(oM_VALID), 0);
    tick;
    check("unload_lat_c2", 32'(oM_VALID), 1);
  endtask

  task automatic do_unload(input int ready_pct, input int stop_after);
    int beats = 0;
    int first = -1;
    int last_c = -1;
    int cyc = 0;
    bit held = 1'b0;
    logic [16:0] h_data;
    logic [10:0] h_idx;
    for (int k = 0; k < 2048; k++) out_q.push_back(k);
    while (cyc < 20000) begin
      bit rdy;
      int k;
      rdy = ($urandom_range(0, 99) < ready_pct);
      iM_READY = rdy;
      if (held) begin
        check("stall_valid", 32'(oM_VALID), 1);
        check("stall_data", 32'(oM_DATA), 32'(h_data));
        check("stall_index", 32'(oM_INDEX), 32'(h_idx));
        held = 1'b0;
      end
      if (oM_VALID) begin
        if (rdy) begin
          k = (out_q.size() > 0) ? out_q.pop_front() : -1;
          check("m_data", 32'(oM_DATA), 32'(k + 1000));
          check("m_index", 32'(oM_INDEX), 32'(k));
          check("m_last", 32'(oM_LAST), 32'(k == 2047));
          if (first < 0) first = cyc;
          last_c = cyc;
          beats++;
        end else begin
          held = 1'b1;
          h_data = oM_DATA;
          h_idx = oM_INDEX;
        end
      end
      if (beats == stop_after) break;
      tick;
      cyc++;
    end
    check("unload_beats", 32'(beats), 32'(stop_after));
    if (stop_after == 2048) begin
      tick;
      iM_READY = 1'b0;
      check("back_in_load_busy", 32'(oBUSY), 0);
      check("back_in_load_ready", 32'(oS_READY), 1);
      check("back_in_load_valid", 32'(oM_VALID), 0);
      if (ready_pct == 100) check("unload_back_to_back", 32'(last_c - first + 1), 32'd2048);
    end
    out_q.delete();
  endtask

  initial begin
    iRESET = 1'b1;
    iS_VALID = 1'b0;
    iS_DATA = '0;
    iRDY = 1'b0;
    iM_READY = 1'b0;
    do_reset();

    // Ramp load, ready level held high through WAIT, full-rate unload
    iRDY = 1'b1;
    do_load(2048, 1'b0, 1'b1);
    do_start_wait(20);
    do_trigger();
    do_unload(100, 2048);

    // Random input valid, random output backpressure
    do_load(2048, 1'b1, 1'b0);
    do_start_wait(5);
    do_trigger();
    do_unload(30, 2048);

    // Reset in the middle of LOAD, then a fresh load from n = 0
    do_load(700, 1'b1, 1'b0);
    check("busy_mid_load", 32'(oBUSY), 1);
    do_reset();
    do_load(2048, 1'b0, 1'b1);
    do_start_wait(3);
    do_trigger();

    // Reset in the middle of UNLOAD, then the next load starts at n = 0
    do_unload(100, 300);
    do_reset();
    do_load(4, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
